// File: rtl/rm_fixed_pkg.sv
// Shared Q8.24 fixed-point definitions used by fixed_sqrt and inv_sqrt.
// Holds the default word geometry, common constants and the iterative-unit state type.
package rm_fixed_pkg;

    localparam int FX_WIDTH     = 32;
    localparam int FX_FRAC_BITS = 24;

    localparam logic [FX_WIDTH-1:0] FP_ONE  = 32'h0100_0000;
    localparam logic [FX_WIDTH-1:0] FP_HALF = 32'h0080_0000;
    localparam logic [FX_WIDTH-1:0] FP_TWO  = 32'h0200_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } fx_state_t;

endpackage

// File: rtl/fixed_sqrt.sv
// Q8.24 square root by radix-2 digit recurrence, one root bit per cycle.
// Negative radicands short-circuit to DONE with neg_err set and a zero root.
module fixed_sqrt
    import rm_fixed_pkg::*;
#(
    parameter int WIDTH     = FX_WIDTH,
    parameter int FRAC_BITS = FX_FRAC_BITS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] x_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] sqrt_out,
    output logic             neg_err,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int RAD_W  = WIDTH + FRAC_BITS;
    localparam int ROOT_W = RAD_W / 2;
    localparam int REM_W  = ROOT_W + 2;
    localparam int CNT_W  = $clog2(ROOT_W);

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ROOT_W - 1);

    fx_state_t state, next_state;

    logic [RAD_W-1:0]  rad;
    logic [ROOT_W-1:0] root;
    logic [REM_W-1:0]  rem;
    logic [CNT_W-1:0]  cnt;

    logic              accept;
    logic              x_neg;
    logic [REM_W+1:0]  shifted;
    logic [REM_W+1:0]  trial;
    logic              no_borrow;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;
    assign x_neg     = x_in[WIDTH-1];
    assign sqrt_out  = {{(WIDTH-ROOT_W){1'b0}}, root};

    // Bring down the next radicand digit pair and test it against 4*root+1.
    always_comb begin
        shifted   = {rem, rad[RAD_W-1 -: 2]};
        trial     = {2'b00, root, 2'b01};
        no_borrow = (shifted >= trial);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    next_state = x_neg ? DONE : CALC;
                end
            end
            CALC: begin
                if (cnt == '0) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rad     <= '0;
            root    <= '0;
            rem     <= '0;
            cnt     <= '0;
            neg_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        root <= '0;
                        rem  <= '0;
                        if (x_neg) begin
                            rad     <= '0;
                            cnt     <= '0;
                            neg_err <= 1'b1;
                        end else begin
                            rad     <= {x_in, {FRAC_BITS{1'b0}}};
                            cnt     <= LAST_ITER;
                            neg_err <= 1'b0;
                        end
                    end
                end
                CALC: begin
                    rad <= rad << 2;
                    if (no_borrow) begin
                        rem  <= REM_W'(shifted - trial);
                        root <= {root[ROOT_W-2:0], 1'b1};
                    end else begin
                        rem  <= REM_W'(shifted);
                        root <= {root[ROOT_W-2:0], 1'b0};
                    end
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/fixed_sqrt.md
FIXED_SQRT -- requirements
Module: fixed_sqrt

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data word width.
REQ-002 SHALL have parameter FRAC_BITS, default 24, fractional bits (Q8.24).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port x_in  input  WIDTH  signed Q8.24 radicand.
REQ-006 SHALL have port in_valid  input  1  x_in valid.
REQ-007 SHALL have port in_ready  output  1  block can accept x_in.
REQ-008 SHALL have port sqrt_out  output  WIDTH  unsigned Q8.24 root.
REQ-009 SHALL have port neg_err  output  1  radicand was negative; qualified by out_valid.
REQ-010 SHALL have port out_valid  output  1  sqrt_out/neg_err valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.

Function
REQ-012 SHALL compute sqrt_out = floor(sqrt(x_in * 2^FRAC_BITS)), i.e. integer root of a (WIDTH+FRAC_BITS)-bit radicand, truncated, no rounding.
REQ-013 SHALL use radix-2 digit recurrence, one result bit per cycle: (WIDTH+FRAC_BITS)/2 = 28 iterations for defaults.
REQ-014 SHALL implement states IDLE, CALC, DONE.
REQ-015 in_ready SHALL be 1 exactly in IDLE; input accepted on an edge where in_valid && in_ready.
REQ-016 IDLE -> CALC on accept with x_in[WIDTH-1]=0; radicand, partial root, remainder and iteration counter loaded.
REQ-017 IDLE -> DONE on accept with x_in[WIDTH-1]=1; sqrt_out=0, neg_err=1, out_valid rises on the next edge (latency 1).
REQ-018 CALC SHALL decrement a 5-bit counter per cycle; after the 28th iteration -> DONE with neg_err=0.
REQ-019 Non-negative latency: out_valid SHALL rise exactly 28 rising edges after the accept edge.
REQ-020 DONE SHALL hold out_valid=1 and sqrt_out/neg_err stable until an edge with out_ready=1, then -> IDLE.
REQ-021 DONE with out_ready=1 SHALL NOT accept new input on the same edge; next accept earliest one cycle later (no overlap).
REQ-022 in_valid during CALC/DONE SHALL be ignored; x_in changes after accept SHALL NOT affect the result.
REQ-023 x_in=0 SHALL run the full 28 cycles and yield 0, neg_err=0.
REQ-024 Maximum input 0x7FFFFFFF SHALL yield 0x0B504F33; root always fits in 28 bits, upper bits of sqrt_out 0.
REQ-025 Remainder width SHALL be 30 bits (root width + 2) to avoid overflow in trial subtraction.

Reset
REQ-026 While rst=1: state=IDLE, in_ready=1, out_valid=0, sqrt_out=0, neg_err=0, counter=0, datapath registers 0.
REQ-027 Reset asserted mid-CALC or in DONE SHALL abort the operation; no result emitted after release.
REQ-028 First accept possible on the first rising edge after rst deasserts.

Structure
REQ-029 WIDTH/FRAC_BITS defaults and Q8.24 constants (FP_ONE, FP_HALF, FP_TWO) SHALL live in shared package rm_fixed_pkg, also used by inv_sqrt.
REQ-030 State enum SHALL be a typedef in rm_fixed_pkg.
REQ-031 No sub-module; iteration datapath inline, single always_ff with async reset plus combinational trial subtract.

Verification
REQ-032 x_in=0x04000000 (4.0) -> after 28 cycles sqrt_out=0x02000000, neg_err=0.
REQ-033 x_in=0x02000000 (2.0) -> 0x016A09E6; x_in=0x00400000 (0.25) -> 0x00800000.
REQ-034 x_in=0x7FFFFFFF -> 0x0B504F33; x_in=0x00000001 -> 0x00001000.
REQ-035 x_in=0xFF000000 (-1.0) -> next cycle out_valid=1, sqrt_out=0, neg_err=1.
REQ-036 out_ready held 0 for 10 cycles in DONE -> outputs stable, in_ready=0; in_valid pulses mid-CALC ignored.
REQ-037 rst pulse at CALC cycle 14 -> out_valid stays 0, in_ready=1; fresh 1.0 input then yields 0x01000000.
